req_encoder_8to3: RTL and testbench
===================================

Name: req_encoder_8to3

Overview:
- Sequential 8-to-3 request encoder: the inverse direction of the team's 3-to-8 decoders.
- Collects eight request lines into a sticky pending register and emits one selected index at a time as a 3-bit code.
- Presents that code on a valid/ready handshake, alongside its one-hot form.
- Sits between interrupt/event sources and a consumer that drives a 3-to-8 decoder.

Parameters:
RR, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin
CNT_W, 8, width of saturating dropped-request counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  8  request lines; a 1 in any cycle sets the matching pending bit
out_ready  input  1  consumer accepts the current code
out_valid  output  1  out_code/out_onehot hold a selected request
out_code  output  3  binary index of selected request
out_onehot  output  8  decode of out_code when out_valid=1, else 8'h00
pending  output  8  pending register (excludes the bit currently presented)
drop_pulse  output  1  one-cycle pulse: a request hit an already-set bit
drop_cnt  output  CNT_W  saturating count of dropped requests

Behaviour:
- Reset (async assert, sync release): pending=0, out_valid=0, out_code=0, out_onehot=0, drop_pulse=0, drop_cnt=0, RR pointer=7, state=IDLE. Outputs clear immediately on assert, mid-transfer included; the presented request is lost.
- Handshake: transfer when out_valid & out_ready at a rising edge. While out_valid=1 and out_ready=0, out_code/out_onehot hold stable regardless of new req. out_valid never deasserts without a transfer, except on reset.
- Pending update, every edge: pending_next = (pending & ~sel_mask) | req.
  - sel_mask is the one-hot of the index being loaded into the output register this edge; else 0.
  - A selected bit leaves pending when loaded into the output.
  - A req bit equal to the bit being loaded re-sets pending (new event, not dropped).
- Drop: req[i]=1 while pending[i]=1 and i not being loaded this edge gives drop_pulse=1 for the next cycle.
  - Multiple simultaneous drops count as 1 per cycle.
  - drop_cnt increments with each drop_pulse and saturates at all-ones.
- Selection operates on the registered pending only; req in the same cycle is never selected directly.
  - RR=0: highest set index.
  - RR=1: first set index searching upward from (ptr+1) mod 8, wrapping. ptr <= accepted index on each transfer.
- FSM:
  - IDLE: out_valid=0. If pending!=0, load selected code/onehot and go to VALID. Else stay.
  - VALID: out_valid=1.
    - If out_ready=1 and pending!=0: load the next selection (back-to-back, no bubble) and stay in VALID.
    - If out_ready=1 and pending=0: go to IDLE with out_valid=0.
    - If out_ready=0: hold.
  - In VALID with out_ready=1, the RR search uses the pointer value being written this edge, i.e. it starts above the index just accepted.
- Latency: req high at edge E0 sets pending after E0; out_valid=1 after E1. This is 2 cycles from an idle start.
- Throughput: one code per cycle while pending is non-empty and out_ready=1.
- out_onehot always equals 1<<out_code while valid.

Test Plan:
- Single: reset, req=8'h20 for 1 cycle, out_ready=1 -> out_valid high 2 cycles later with out_code=5, out_onehot=8'h20, for exactly 1 cycle; pending=0 afterwards.
- Fixed priority with stall: RR=0, req=8'h8A for 1 cycle, out_ready=0 for 4 cycles, then 1 -> code 7 held stable during the stall, then codes 3 and 1 back-to-back, then out_valid=0.
- Round-robin: RR=1, req=8'hFF held 1 cycle, then req=8'h01 pulsed each time code 7 is accepted, out_ready=1 -> codes 0,1,...,7,0; no index is repeated before all pending bits are served.
- Drop/saturate: CNT_W=2, req=8'h01 while bit 0 pending and out_ready=0, for 5 cycles -> drop_pulse high 4 cycles; drop_cnt is 3 and stays at 3.
- Re-arm: bit 4 being loaded and req[4]=1 on the same edge -> no drop_pulse; code 4 is presented twice.
- Reset mid-transfer: out_valid=1, pending=8'h0C, assert reset between edges -> all outputs 0 immediately; after release with req=0, out_valid stays 0.

Source files
------------

// File: rtl/req_encoder_8to3.sv
// Sticky 8-to-3 request encoder: pending bits are served one at a time on a valid/ready output.
// Two-cycle idle-to-valid latency, one code per cycle when the consumer is ready; holds on stall.
module req_encoder_8to3 #(
  parameter int RR    = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [2:0]       out_code,
  output logic [7:0]       out_onehot,
  output logic [7:0]       pending,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {S_IDLE, S_VALID} state_t;

  state_t           r_state;
  logic [7:0]       r_pending;
  logic [2:0]       r_code;
  logic [7:0]       r_onehot;
  logic [2:0]       r_ptr;
  logic             r_drop;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_load;
  logic [2:0]       w_start;
  logic [2:0]       w_sel;
  logic             w_found;
  logic [7:0]       w_mask;
  logic             w_drop;

  assign w_accept = (r_state == S_VALID) && out_ready;
  assign w_load   = ((r_state == S_IDLE) || out_ready) && (|r_pending);
  // On a transfer the round-robin search starts just above the index being accepted.
  assign w_start  = w_accept ? r_code : r_ptr;

  always_comb begin
    w_sel   = 3'd0;
    w_found = 1'b0;
    if (RR == 0) begin
      for (int i = 7; i >= 0; i--) begin
        if (!w_found && r_pending[i]) begin
          w_sel   = 3'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        if (!w_found && r_pending[w_start + 3'(k)]) begin
          w_sel   = w_start + 3'(k);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_mask = w_load ? (8'd1 << w_sel) : 8'd0;
  assign w_drop = |(req & r_pending & ~w_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= 8'h00;
      r_code    <= 3'd0;
      r_onehot  <= 8'h00;
      r_ptr     <= 3'd7;
      r_drop    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_mask) | req;
      r_drop    <= w_drop;
      if (w_drop && !(&r_cnt)) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_accept) begin
        r_ptr <= r_code;
      end
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_code   <= w_sel;
            r_onehot <= w_mask;
            r_state  <= S_VALID;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            if (w_load) begin
              r_code   <= w_sel;
              r_onehot <= w_mask;
            end else begin
              r_onehot <= 8'h00;
              r_state  <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = (r_state == S_VALID);
  assign out_code   = r_code;
  assign out_onehot = r_onehot;
  assign pending    = r_pending;
  assign drop_pulse = r_drop;
  assign drop_cnt   = r_cnt;

endmodule

// File: tb/tb_req_encoder_8to3.sv
// Bench for req_encoder_8to3: fixed-priority (CNT_W=2) and round-robin instances share stimulus
// and are compared every cycle against a behavioural model, plus directed scenario checks.
module tb_req_encoder_8to3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic       out_ready = 1'b0;

  logic       fp_valid, rr_valid;
  logic [2:0] fp_code, rr_code;
  logic [7:0] fp_onehot, rr_onehot, fp_pend, rr_pend;
  logic       fp_drop, rr_drop;
  logic [1:0] fp_cnt;
  logic [7:0] rr_cnt;

  int total = 0;
  int bad   = 0;

  // model state: index 0 = fixed priority, 1 = round robin
  logic [7:0] m_pend  [2];
  logic       m_valid [2];
  int         m_code  [2];
  int         m_ptr   [2];
  logic       m_drop  [2];
  int         m_cnt   [2];
  int         m_max   [2];

  int got [$];

  always #5 clk = ~clk;

  req_encoder_8to3 #(.RR(0), .CNT_W(2)) u_fp (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .out_valid(fp_valid), .out_code(fp_code), .out_onehot(fp_onehot),
    .pending(fp_pend), .drop_pulse(fp_drop), .drop_cnt(fp_cnt)
  );

  req_encoder_8to3 #(.RR(1), .CNT_W(8)) u_rr (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .out_valid(rr_valid), .out_code(rr_code), .out_onehot(rr_onehot),
    .pending(rr_pend), .drop_pulse(rr_drop), .drop_cnt(rr_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int rr, input logic [7:0] pend, input int start);
    if (rr != 0) begin
      for (int k = 1; k <= 8; k++) begin
        if (pend[(start + k) % 8]) return (start + k) % 8;
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend[i]) return i;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      m_pend[j] = 8'h00; m_valid[j] = 1'b0; m_code[j] = 0;
      m_ptr[j] = 7; m_drop[j] = 1'b0; m_cnt[j] = 0;
    end
    m_max[0] = 3;
    m_max[1] = 255;
  endtask

  task automatic model_step(input logic [7:0] r, input logic rdy);
    for (int j = 0; j < 2; j++) begin
      logic       acc, can;
      int         p;
      logic [7:0] mask;
      acc  = m_valid[j] && rdy;
      can  = (!m_valid[j] || rdy) && (m_pend[j] != 8'h00);
      p    = pick(j, m_pend[j], acc ? m_code[j] : m_ptr[j]);
      mask = can ? (8'h01 << p) : 8'h00;
      m_drop[j] = ((r & m_pend[j] & ~mask) != 8'h00);
      if (m_drop[j] && m_cnt[j] < m_max[j]) m_cnt[j]++;
      m_pend[j] = (m_pend[j] & ~mask) | r;
      if (acc) m_ptr[j] = m_code[j];
      if (can) begin
        m_valid[j] = 1'b1;
        m_code[j]  = p;
      end else if (acc) begin
        m_valid[j] = 1'b0;
      end
    end
  endtask

  task automatic check_inst(input string nm, input int j, input logic v, input logic [2:0] c,
                            input logic [7:0] oh, input logic [7:0] pd, input logic dp, input int cnt);
    chk({nm, "_valid"}, 32'(v), 32'(m_valid[j]));
    if (m_valid[j]) begin
      chk({nm, "_code"}, 32'(c), 32'(m_code[j]));
      chk({nm, "_onehot"}, 32'(oh), 32'(8'h01 << m_code[j]));
    end else begin
      chk({nm, "_onehot_idle"}, 32'(oh), 32'h0);
    end
    chk({nm, "_pending"}, 32'(pd), 32'(m_pend[j]));
    chk({nm, "_drop_pulse"}, 32'(dp), 32'(m_drop[j]));
    chk({nm, "_drop_cnt"}, 32'(cnt), 32'(m_cnt[j]));
  endtask

  task automatic check_all();
    check_inst("fp", 0, fp_valid, fp_code, fp_onehot, fp_pend, fp_drop, int'(fp_cnt));
    check_inst("rr", 1, rr_valid, rr_code, rr_onehot, rr_pend, rr_drop, int'(rr_cnt));
  endtask

  task automatic cycle(input logic [7:0] r, input logic rdy);
    req       = r;
    out_ready = rdy;
    @(posedge clk);
    model_step(r, rdy);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_code", 32'(fp_code), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single request, two-cycle latency, one-cycle valid
    cycle(8'h20, 1'b1);
    chk("single_lat_e0", 32'(fp_valid), 32'h0);
    cycle(8'h00, 1'b1);
    chk("single_code", 32'(fp_code), 32'd5);
    chk("single_onehot", 32'(fp_onehot), 32'h20);
    cycle(8'h00, 1'b1);
    chk("single_done", 32'(fp_valid), 32'h0);
    chk("single_pend", 32'(fp_pend), 32'h0);

    // fixed priority with stall
    do_reset();
    cycle(8'h8A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(8'h00, 1'b0);
      chk("fp_stall_code", 32'(fp_code), 32'd7);
    end
    cycle(8'h00, 1'b1);
    chk("fp_code3", 32'(fp_code), 32'd3);
    cycle(8'h00, 1'b1);
    chk("fp_code1", 32'(fp_code), 32'd1);
    cycle(8'h00, 1'b1);
    chk("fp_end", 32'(fp_valid), 32'h0);

    // round robin: 0..7 then 0 again from a re-pulsed bit 0
    do_reset();
    cycle(8'hFF, 1'b1);
    got.delete();
    for (int i = 0; i < 14; i++) begin
      if (rr_valid) got.push_back(int'(rr_code));
      cycle((rr_valid && rr_code == 3'd7) ? 8'h01 : 8'h00, 1'b1);
    end
    chk("rr_count_ok", 32'(got.size() >= 9), 32'h1);
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      chk("rr_order", 32'(got[i]), 32'(i % 8));
    end

    // drop and saturation (fp instance has a 2-bit counter)
    do_reset();
    cycle(8'h01, 1'b0);
    for (int i = 0; i < 5; i++) cycle(8'h01, 1'b0);
    chk("fp_sat_cnt", 32'(fp_cnt), 32'd3);
    cycle(8'h01, 1'b0);
    chk("fp_sat_hold", 32'(fp_cnt), 32'd3);
    chk("rr_cnt_5", 32'(rr_cnt), 32'd5);

    // re-arm: bit 4 requested on the edge it is loaded
    do_reset();
    cycle(8'h10, 1'b1);
    cycle(8'h10, 1'b1);
    chk("rearm_no_drop", 32'(fp_drop), 32'h0);
    chk("rearm_code_a", 32'(fp_code), 32'd4);
    cycle(8'h00, 1'b1);
    chk("rearm_code_b", 32'(fp_code), 32'd4);
    chk("rearm_valid_b", 32'(fp_valid), 32'h1);
    cycle(8'h00, 1'b1);
    chk("rearm_end", 32'(fp_valid), 32'h0);

    // reset asserted mid-transfer
    do_reset();
    cycle(8'h1C, 1'b0);
    cycle(8'h00, 1'b0);
    chk("mid_pend", 32'(fp_pend), 32'h0C);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_valid", 32'(fp_valid), 32'h0);
    chk("mid_pend0", 32'(fp_pend), 32'h0);
    chk("mid_onehot", 32'(fp_onehot), 32'h0);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cycle(r, 1'(($urandom % 4) != 0));
    end
    for (int i = 0; i < 20; i++) cycle(8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
